// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered ALU, SFU and BRU lanes carrying ROB tags to writeback.
// Define EX_SFU_DIV_EN to build the iterative divider and its FSM into the SFU lane.
module ex_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alu_valid_i,
    input  logic [XLEN-1:0]  alu_a,
    input  logic [XLEN-1:0]  alu_b,
    input  logic [2:0]       alu_ctrl,
    input  logic [TAG_W-1:0] alu_tag_i,
    output logic             alu_valid_o,
    output logic [XLEN-1:0]  alu_out,
    output logic             alu_ovf,
    output logic [TAG_W-1:0] alu_tag_o,
    input  logic             sfu_valid_i,
    output logic             sfu_ready_o,
    input  logic [XLEN-1:0]  sfu_a,
    input  logic [XLEN-1:0]  sfu_b,
    input  logic [1:0]       sfu_ctrl,
    input  logic [TAG_W-1:0] sfu_tag_i,
    output logic             sfu_valid_o,
    output logic [XLEN-1:0]  sfu_out,
    output logic [TAG_W-1:0] sfu_tag_o,
    input  logic             bru_valid_i,
    input  logic [XLEN-1:0]  bru_a,
    input  logic [XLEN-1:0]  bru_b,
    input  logic [XLEN-1:0]  bru_pc,
    input  logic [XLEN-1:0]  bru_imm,
    input  logic [2:0]       bru_ctrl,
    input  logic             pre_dir_i,
    input  logic [XLEN-1:0]  pre_addr_i,
    input  logic [TAG_W-1:0] bru_tag_i,
    output logic             bru_valid_o,
    output logic             pre_right_o,
    output logic             b_type_o,
    output logic             real_dir_o,
    output logic [XLEN-1:0]  addr_o,
    output logic [TAG_W-1:0] bru_tag_o
);

    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] alu_res;
    logic            alu_v;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        unique case (alu_ctrl)
            3'b000: begin
                alu_res = alu_a + alu_b;
                alu_v   = (alu_a[XLEN-1] == alu_b[XLEN-1]) &&
                          (alu_res[XLEN-1] != alu_a[XLEN-1]);
            end
            3'b001: begin
                alu_res = alu_a - alu_b;
                alu_v   = (alu_a[XLEN-1] != alu_b[XLEN-1]) &&
                          (alu_res[XLEN-1] != alu_a[XLEN-1]);
            end
            3'b010: alu_res = alu_a & alu_b;
            3'b011: alu_res = alu_a | alu_b;
            3'b100: alu_res = alu_a ^ alu_b;
            3'b101: alu_res = {{(XLEN-1){1'b0}},
                               $signed(alu_a) < $signed(alu_b)};
            3'b110: alu_res = alu_a << alu_b[SH_W-1:0];
            3'b111: alu_res = alu_a >> alu_b[SH_W-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid_o <= 1'b0;
            alu_out     <= '0;
            alu_ovf     <= 1'b0;
            alu_tag_o   <= '0;
        end else begin
            alu_valid_o <= alu_valid_i && !flush;
            if (alu_valid_i && !flush) begin
                alu_out   <= alu_res;
                alu_ovf   <= alu_v;
                alu_tag_o <= alu_tag_i;
            end
        end
    end

    logic            br_dir;
    logic            br_btype;
    logic [XLEN-1:0] br_jalr;
    logic [XLEN-1:0] br_next;

    always_comb begin
        br_dir = 1'b1;
        unique case (bru_ctrl)
            3'b000:         br_dir = bru_a == bru_b;
            3'b001:         br_dir = bru_a != bru_b;
            3'b100:         br_dir = $signed(bru_a) < $signed(bru_b);
            3'b101:         br_dir = $signed(bru_a) >= $signed(bru_b);
            3'b110:         br_dir = bru_a < bru_b;
            3'b111:         br_dir = bru_a >= bru_b;
            3'b010, 3'b011: br_dir = 1'b1;
        endcase
    end

    assign br_btype = bru_ctrl[2:1] != 2'b01;
    assign br_jalr  = (bru_a + bru_imm) & ~XLEN'(1);
    assign br_next  = (bru_ctrl == 3'b011) ? br_jalr :
                      br_dir ? bru_pc + bru_imm : bru_pc + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bru_valid_o <= 1'b0;
            pre_right_o <= 1'b0;
            b_type_o    <= 1'b0;
            real_dir_o  <= 1'b0;
            addr_o      <= '0;
            bru_tag_o   <= '0;
        end else begin
            bru_valid_o <= bru_valid_i && !flush;
            if (bru_valid_i && !flush) begin
                pre_right_o <= (br_dir == pre_dir_i) &&
                               (!br_dir || br_next == pre_addr_i);
                b_type_o    <= br_btype;
                real_dir_o  <= br_dir;
                addr_o      <= br_next;
                bru_tag_o   <= bru_tag_i;
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;

    assign prod    = {{XLEN{1'b0}}, sfu_a} * {{XLEN{1'b0}}, sfu_b};
    assign mul_res = sfu_ctrl[0] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

`ifdef EX_SFU_DIV_EN
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] dq;
    logic [XLEN-1:0] dr;
    logic [XLEN-1:0] dd;
    logic            want_rem;
    logic [XLEN:0]   div_try;
    logic [XLEN:0]   div_diff;
    logic            div_ge;

    // One restoring step: shift the next dividend bit into the remainder.
    assign div_try  = {dr, dq[XLEN-1]};
    assign div_diff = div_try - {1'b0, dd};
    assign div_ge   = div_try >= {1'b0, dd};

    assign sfu_ready_o = state != S_DIV;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dq          <= '0;
            dr          <= '0;
            dd          <= '0;
            want_rem    <= 1'b0;
            sfu_valid_o <= 1'b0;
            sfu_out     <= '0;
            sfu_tag_o   <= '0;
        end else if (flush) begin
            state       <= S_IDLE;
            sfu_valid_o <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    state       <= S_IDLE;
                    sfu_valid_o <= 1'b0;
                    if (sfu_valid_i && !sfu_ctrl[1]) begin
                        sfu_valid_o <= 1'b1;
                        sfu_out     <= mul_res;
                        sfu_tag_o   <= sfu_tag_i;
                    end else if (sfu_valid_i) begin
                        state     <= S_DIV;
                        cnt       <= CNT_W'(XLEN);
                        dq        <= sfu_a;
                        dr        <= '0;
                        dd        <= sfu_b;
                        want_rem  <= sfu_ctrl[0];
                        sfu_tag_o <= sfu_tag_i;
                    end
                end
                S_DIV: begin
                    if (cnt == '0) begin
                        state       <= S_DONE;
                        sfu_valid_o <= 1'b1;
                        sfu_out     <= want_rem ? dr : dq;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        dq  <= {dq[XLEN-2:0], div_ge};
                        dr  <= div_ge ? div_diff[XLEN-1:0]
                                      : div_try[XLEN-1:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign sfu_ready_o = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sfu_valid_o <= 1'b0;
            sfu_out     <= '0;
            sfu_tag_o   <= '0;
        end else begin
            sfu_valid_o <= sfu_valid_i && !flush;
            if (sfu_valid_i && !flush) begin
                sfu_out   <= sfu_ctrl[1] ? '0 : mul_res;
                sfu_tag_o <= sfu_tag_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: random and directed stimulus for ex_stage_pipe against a
// cycle-level behavioural model (divider timing follows EX_SFU_DIV_EN).
module tb_ex_stage_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             alu_valid_i = 1'b0;
    logic [XLEN-1:0]  alu_a = '0, alu_b = '0;
    logic [2:0]       alu_ctrl = '0;
    logic [TAG_W-1:0] alu_tag_i = '0;
    logic             alu_valid_o, alu_ovf;
    logic [XLEN-1:0]  alu_out;
    logic [TAG_W-1:0] alu_tag_o;
    logic             sfu_valid_i = 1'b0;
    logic             sfu_ready_o;
    logic [XLEN-1:0]  sfu_a = '0, sfu_b = '0;
    logic [1:0]       sfu_ctrl = '0;
    logic [TAG_W-1:0] sfu_tag_i = '0;
    logic             sfu_valid_o;
    logic [XLEN-1:0]  sfu_out;
    logic [TAG_W-1:0] sfu_tag_o;
    logic             bru_valid_i = 1'b0;
    logic [XLEN-1:0]  bru_a = '0, bru_b = '0, bru_pc = '0, bru_imm = '0;
    logic [2:0]       bru_ctrl = '0;
    logic             pre_dir_i = 1'b0;
    logic [XLEN-1:0]  pre_addr_i = '0;
    logic [TAG_W-1:0] bru_tag_i = '0;
    logic             bru_valid_o, pre_right_o, b_type_o, real_dir_o;
    logic [XLEN-1:0]  addr_o;
    logic [TAG_W-1:0] bru_tag_o;

    always #5 clk = ~clk;

    ex_stage_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid_i(alu_valid_i), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_tag_i(alu_tag_i),
        .alu_valid_o(alu_valid_o), .alu_out(alu_out), .alu_ovf(alu_ovf),
        .alu_tag_o(alu_tag_o),
        .sfu_valid_i(sfu_valid_i), .sfu_ready_o(sfu_ready_o),
        .sfu_a(sfu_a), .sfu_b(sfu_b), .sfu_ctrl(sfu_ctrl),
        .sfu_tag_i(sfu_tag_i), .sfu_valid_o(sfu_valid_o),
        .sfu_out(sfu_out), .sfu_tag_o(sfu_tag_o),
        .bru_valid_i(bru_valid_i), .bru_a(bru_a), .bru_b(bru_b),
        .bru_pc(bru_pc), .bru_imm(bru_imm), .bru_ctrl(bru_ctrl),
        .pre_dir_i(pre_dir_i), .pre_addr_i(pre_addr_i),
        .bru_tag_i(bru_tag_i), .bru_valid_o(bru_valid_o),
        .pre_right_o(pre_right_o), .b_type_o(b_type_o),
        .real_dir_o(real_dir_o), .addr_o(addr_o), .bru_tag_o(bru_tag_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: what the outputs should show after the latest edge.
    logic             m_alu_v, m_alu_ovf;
    logic [XLEN-1:0]  m_alu_out;
    logic [TAG_W-1:0] m_alu_tag;
    logic             m_sfu_v;
    logic [XLEN-1:0]  m_sfu_out, m_pend;
    logic [TAG_W-1:0] m_sfu_tag, m_pend_tag;
    int               m_wait;
    logic             m_bru_v, m_pr, m_bt, m_dir;
    logic [XLEN-1:0]  m_addr;
    logic [TAG_W-1:0] m_bru_tag;

    task automatic model_reset();
        m_alu_v = 0; m_alu_ovf = 0; m_alu_out = '0; m_alu_tag = '0;
        m_sfu_v = 0; m_sfu_out = '0; m_sfu_tag = '0; m_wait = 0;
        m_pend = '0; m_pend_tag = '0;
        m_bru_v = 0; m_pr = 0; m_bt = 0; m_dir = 0; m_addr = '0;
        m_bru_tag = '0;
    endtask

    task automatic alu_ref(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] r,
                           output logic o);
        longint s;
        int     sh;
        sh = int'(b % 32);
        o = 1'b0;
        case (op)
            3'd0: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                o = (s > SMAX) || (s < SMIN);
            end
            3'd1: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                o = (s > SMAX) || (s < SMIN);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: r = a << sh;
            default: r = a >> sh;
        endcase
    endtask

    task automatic bru_ref(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc,
                           input logic [31:0] imm, output logic d,
                           output logic bt, output logic [31:0] nxt);
        bt = !(op == 3'd2 || op == 3'd3);
        case (op)
            3'd0: d = a == b;
            3'd1: d = a != b;
            3'd4: d = $signed(a) < $signed(b);
            3'd5: d = $signed(a) >= $signed(b);
            3'd6: d = a < b;
            3'd7: d = a >= b;
            default: d = 1'b1;
        endcase
        if (op == 3'd3) nxt = (a + imm) & 32'hFFFF_FFFE;
        else if (d) nxt = pc + imm;
        else nxt = pc + 32'd4;
    endtask

    task automatic model_edge();
        logic [63:0] p;
        logic [31:0] r, nx;
        logic        o, d, bt;
        if (rst) begin
            model_reset();
            return;
        end
        if (flush) begin
            m_alu_v = 0; m_sfu_v = 0; m_bru_v = 0; m_wait = 0;
            return;
        end
        m_alu_v = alu_valid_i;
        if (alu_valid_i) begin
            alu_ref(alu_ctrl, alu_a, alu_b, r, o);
            m_alu_out = r; m_alu_ovf = o; m_alu_tag = alu_tag_i;
        end
        m_bru_v = bru_valid_i;
        if (bru_valid_i) begin
            bru_ref(bru_ctrl, bru_a, bru_b, bru_pc, bru_imm, d, bt, nx);
            m_dir = d; m_bt = bt; m_addr = nx; m_bru_tag = bru_tag_i;
            m_pr = (d == pre_dir_i) && (!d || nx == pre_addr_i);
        end
        p = 64'(sfu_a) * 64'(sfu_b);
`ifdef EX_SFU_DIV_EN
        if (m_wait > 0) begin
            m_wait--;
            m_sfu_v = (m_wait == 0);
            if (m_wait == 0) begin
                m_sfu_out = m_pend; m_sfu_tag = m_pend_tag;
            end
        end else begin
            m_sfu_v = 0;
            if (sfu_valid_i && !sfu_ctrl[1]) begin
                m_sfu_v = 1;
                m_sfu_out = sfu_ctrl[0] ? p[63:32] : p[31:0];
                m_sfu_tag = sfu_tag_i;
            end else if (sfu_valid_i) begin
                m_wait = XLEN + 1;
                m_pend_tag = sfu_tag_i;
                if (sfu_b == 0) m_pend = sfu_ctrl[0] ? sfu_a : 32'hFFFF_FFFF;
                else m_pend = sfu_ctrl[0] ? sfu_a % sfu_b : sfu_a / sfu_b;
            end
        end
`else
        m_sfu_v = sfu_valid_i;
        if (sfu_valid_i) begin
            m_sfu_tag = sfu_tag_i;
            if (sfu_ctrl[1]) m_sfu_out = '0;
            else m_sfu_out = sfu_ctrl[0] ? p[63:32] : p[31:0];
        end
`endif
    endtask

    task automatic compare();
        chk("alu_valid", 64'(alu_valid_o), 64'(m_alu_v));
        if (m_alu_v) begin
            chk("alu_out", 64'(alu_out), 64'(m_alu_out));
            chk("alu_ovf", 64'(alu_ovf), 64'(m_alu_ovf));
            chk("alu_tag", 64'(alu_tag_o), 64'(m_alu_tag));
        end
        chk("sfu_ready", 64'(sfu_ready_o), 64'(m_wait == 0));
        chk("sfu_valid", 64'(sfu_valid_o), 64'(m_sfu_v));
        if (m_sfu_v) begin
            chk("sfu_out", 64'(sfu_out), 64'(m_sfu_out));
            chk("sfu_tag", 64'(sfu_tag_o), 64'(m_sfu_tag));
        end
        chk("bru_valid", 64'(bru_valid_o), 64'(m_bru_v));
        if (m_bru_v) begin
            chk("pre_right", 64'(pre_right_o), 64'(m_pr));
            chk("b_type", 64'(b_type_o), 64'(m_bt));
            chk("real_dir", 64'(real_dir_o), 64'(m_dir));
            chk("addr", 64'(addr_o), 64'(m_addr));
            chk("bru_tag", 64'(bru_tag_o), 64'(m_bru_tag));
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic clear_in();
        alu_valid_i = 0; sfu_valid_i = 0; bru_valid_i = 0; flush = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_div(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp,
                           input string name);
        int          low;
        logic [31:0] got;
        logic        seen;
        low = 0; got = '0; seen = 0;
        clear_in();
        sfu_valid_i = 1; sfu_ctrl = op; sfu_a = a; sfu_b = b;
        sfu_tag_i = 6'($urandom);
        cycle();
        sfu_valid_i = 0;
        for (int i = 0; i < XLEN + 3; i++) begin
            if (!sfu_ready_o) low++;
            if (sfu_valid_o) begin
                got = sfu_out; seen = 1;
            end
            cycle();
        end
        chk({name, "_seen"}, 64'(seen), 64'(1));
`ifdef EX_SFU_DIV_EN
        chk({name, "_ready_low"}, 64'(low), 64'(XLEN + 1));
        chk(name, 64'(got), 64'(exp));
`else
        chk({name, "_ready_low"}, 64'(low), 64'(0));
        chk(name, 64'(got), 64'(0));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_valid", 64'(alu_valid_o), 64'(0));
        chk("rst_alu_out", 64'(alu_out), 64'(0));
        chk("rst_sfu_valid", 64'(sfu_valid_o), 64'(0));
        chk("rst_sfu_ready", 64'(sfu_ready_o), 64'(1));
        chk("rst_bru_valid", 64'(bru_valid_o), 64'(0));
        chk("rst_addr", 64'(addr_o), 64'(0));
        rst = 0;

        alu_valid_i = 1; alu_ctrl = 3'd0; alu_tag_i = 6'd5;
        alu_a = 32'h7FFF_FFFF; alu_b = 32'd1;
        cycle();
        chk("add_ovf_out", 64'(alu_out), 64'h8000_0000);
        chk("add_ovf_flag", 64'(alu_ovf), 64'(1));
        chk("add_ovf_tag", 64'(alu_tag_o), 64'(5));
        alu_ctrl = 3'd1; alu_a = 32'd3; alu_b = 32'd5;
        cycle();
        chk("sub_out", 64'(alu_out), 64'hFFFF_FFFE);
        chk("sub_ovf", 64'(alu_ovf), 64'(0));
        clear_in();

        sfu_valid_i = 1; sfu_ctrl = 2'b01;
        sfu_a = 32'hFFFF_FFFF; sfu_b = 32'd2;
        cycle();
        chk("mulhu", 64'(sfu_out), 64'(1));
        sfu_ctrl = 2'b00; sfu_a = 32'd6; sfu_b = 32'd7;
        cycle();
        chk("mul", 64'(sfu_out), 64'(42));
        chk("mul_valid", 64'(sfu_valid_o), 64'(1));
        clear_in();

        bru_valid_i = 1; bru_ctrl = 3'd1; bru_a = 32'd1; bru_b = 32'd2;
        bru_pc = 32'h100; bru_imm = 32'h20; pre_dir_i = 1;
        pre_addr_i = 32'h120;
        cycle();
        chk("bne_dir", 64'(real_dir_o), 64'(1));
        chk("bne_addr", 64'(addr_o), 64'h120);
        chk("bne_right", 64'(pre_right_o), 64'(1));
        pre_addr_i = 32'h124;
        cycle();
        chk("bne_wrong", 64'(pre_right_o), 64'(0));
        bru_ctrl = 3'd3; bru_a = 32'h203; bru_imm = 32'h0;
        cycle();
        chk("jalr_addr", 64'(addr_o), 64'h202);
        chk("jalr_btype", 64'(b_type_o), 64'(0));
        clear_in();

        run_div(2'b10, 32'd100, 32'd7, 32'd14, "divu_100_7");
        run_div(2'b11, 32'd100, 32'd7, 32'd2, "remu_100_7");
        run_div(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_5_0");
        run_div(2'b11, 32'd5, 32'd0, 32'd5, "remu_5_0");

        // Mul issued in the result cycle of a divide.
        sfu_valid_i = 1; sfu_ctrl = 2'b10; sfu_a = 32'd50; sfu_b = 32'd5;
        cycle();
        sfu_valid_i = 0;
        for (int i = 0; i < XLEN + 3 && !sfu_valid_o; i++) cycle();
        chk("done_seen", 64'(sfu_valid_o), 64'(1));
        sfu_valid_i = 1; sfu_ctrl = 2'b00; sfu_a = 32'd3; sfu_b = 32'd4;
        cycle();
        chk("mul_after_div", 64'(sfu_out), 64'(12));
        clear_in();
        cycle();

        sfu_valid_i = 1; sfu_ctrl = 2'b10; sfu_a = 32'd1000; sfu_b = 32'd3;
        cycle();
        sfu_valid_i = 0;
        repeat (10) cycle();
        flush = 1;
        cycle();
        flush = 0;
        chk("flush_ready", 64'(sfu_ready_o), 64'(1));
        chk("flush_novalid", 64'(sfu_valid_o), 64'(0));
        repeat (XLEN + 4) cycle();
        run_div(2'b10, 32'd9, 32'd3, 32'd3, "divu_9_3");

        sfu_valid_i = 1; sfu_ctrl = 2'b10; sfu_a = 32'd100; sfu_b = 32'd7;
        alu_valid_i = 1; alu_ctrl = 3'd2; alu_a = 32'hF0; alu_b = 32'h3C;
        cycle();
        sfu_valid_i = 0;
        repeat (4) cycle();
        rst = 1;
        #1;
        chk("arst_alu_valid", 64'(alu_valid_o), 64'(0));
        chk("arst_sfu_valid", 64'(sfu_valid_o), 64'(0));
        chk("arst_bru_valid", 64'(bru_valid_o), 64'(0));
        chk("arst_ready", 64'(sfu_ready_o), 64'(1));
        model_reset();
        cycle();
        rst = 0;
        clear_in();

        for (int n = 0; n < 2500; n++) begin
            logic [31:0] nx;
            logic        d, bt;
            alu_valid_i = 1'($urandom);
            alu_ctrl = 3'($urandom);
            alu_a = pick(); alu_b = pick();
            alu_tag_i = 6'($urandom);
            sfu_valid_i = 1'($urandom);
            sfu_ctrl = 2'($urandom);
            sfu_a = pick();
            sfu_b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            sfu_tag_i = 6'($urandom);
            bru_valid_i = 1'($urandom);
            bru_ctrl = 3'($urandom);
            bru_a = pick(); bru_b = pick();
            bru_pc = $urandom; bru_imm = pick();
            bru_tag_i = 6'($urandom);
            pre_dir_i = 1'($urandom);
            bru_ref(bru_ctrl, bru_a, bru_b, bru_pc, bru_imm, d, bt, nx);
            pre_addr_i = $urandom_range(0, 1) ? nx : $urandom;
            flush = ($urandom_range(0, 49) == 0);
            cycle();
        end
        clear_in();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Registered, parametrised execution stage for the out-of-order core. It sits between issue/register-read and the writeback/ROB-complete bus, and carries each result's ROB tag through to writeback. Three execution lanes:
- ALU: single-cycle, registered.
- SFU: multiply plus an optional iterative divider, with a valid/ready handshake.
- BRU: registered branch resolve.

A global flush kills all in-flight work.

## Interface
Parameters:
- XLEN, 32, datapath width (≥8, even)
- TAG_W, 6, ROB tag width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kill all in-flight ops; inputs in the same cycle are ignored
- alu_valid_i  in  1  ALU op present
- alu_a, alu_b  in  XLEN  ALU operands
- alu_ctrl  in  3  ALU op
- alu_tag_i  in  TAG_W  ALU destination tag
- alu_valid_o  out  1  ALU result valid
- alu_out  out  XLEN  ALU result
- alu_ovf  out  1  signed overflow
- alu_tag_o  out  TAG_W  ALU result tag
- sfu_valid_i  in  1  SFU op present
- sfu_ready_o  out  1  SFU can accept
- sfu_a, sfu_b  in  XLEN  SFU operands
- sfu_ctrl  in  2  SFU op
- sfu_tag_i  in  TAG_W  SFU destination tag
- sfu_valid_o  out  1  SFU result valid
- sfu_out  out  XLEN  SFU result
- sfu_tag_o  out  TAG_W  SFU result tag
- bru_valid_i  in  1  branch op present
- bru_a, bru_b  in  XLEN  compare operands (bru_a is also the jalr base)
- bru_pc, bru_imm  in  XLEN  branch PC and offset
- bru_ctrl  in  3  branch op
- pre_dir_i  in  1  predicted direction
- pre_addr_i  in  XLEN  predicted target
- bru_tag_i  in  TAG_W  branch tag
- bru_valid_o  out  1  branch resolved
- pre_right_o  out  1  prediction correct
- b_type_o  out  1  conditional branch
- real_dir_o  out  1  actual direction
- addr_o  out  XLEN  actual next PC
- bru_tag_o  out  TAG_W  branch result tag

## Operation

**ALU ctrl**
- 000 add, 001 sub, 010 and, 011 or, 100 xor
- 101 slt (signed, result 1 or 0)
- 110 sll, 111 srl; shift amount is b[$clog2(XLEN)-1:0]
- alu_ovf is set only for add/sub with signed overflow; it is 0 for all other ops.

**SFU ctrl**
- 00 mul low XLEN bits
- 01 mulhu, unsigned high XLEN bits
- 10 divu
- 11 remu
- Divide by zero: divu = all ones, remu = a.

**BRU ctrl**
- 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu, 010 jal, 011 jalr.
- b_type_o is 1 except for 010 and 011.
- real_dir_o is the compare result for B-type ops and 1 for jumps.
- addr_o:
  - jalr: (a+imm) & ~1
  - taken: pc+imm
  - not taken: pc+4
- pre_right_o = (real_dir==pre_dir) && (!real_dir || addr_o==pre_addr_i).

**SFU FSM states**
- IDLE: a mul op is accepted every cycle. A div op goes to DIV with counter = XLEN.
- DIV: restoring shift-subtract, one quotient bit per cycle, counter decrements. At 0 go to DONE.
- DONE: sfu_valid_o=1 for one cycle, then return to IDLE. A new op may be accepted in DONE.
- sfu_ready_o = (state != DIV), which is 1 after reset.
- An op is accepted only when sfu_valid_i && sfu_ready_o.

**Flush**
- At the flush edge, all *_valid_o go to 0 and the FSM goes to IDLE; the divider is abandoned.
- Data and tag registers may keep stale values.

**Reset**
- All outputs are 0 except sfu_ready_o=1. FSM is in IDLE.

## Timing
- ALU and BRU: 1-cycle latency. An op on edge t appears on outputs after edge t; throughput is 1 per cycle. *_valid_o is high for exactly one cycle per op.
- Mul: 1-cycle latency, fully pipelined.
- Div: accepted at edge t, sfu_valid_o is high in the cycle after edge t+XLEN+1. sfu_ready_o is low for XLEN+1 cycles.
- Mul accepted while a div result is in DONE: the mul result follows in the next cycle, with no collision.
- Reset asserted mid-divide: immediate return to IDLE, no output.

## Configuration
- `EX_SFU_DIV_EN` defined: iterative divider and FSM as above.
- `EX_SFU_DIV_EN` undefined: no FSM. ctrl 10/11 return 0 with 1-cycle latency, and sfu_ready_o is tied to 1.

## Test plan
- ALU add 0x7FFFFFFF+1, tag 5 -> next cycle alu_out=0x80000000, alu_ovf=1, alu_tag_o=5; sub 3-5 -> 0xFFFFFFFE, ovf=0.
- SFU divu 100/7 -> sfu_ready_o low 33 cycles, then out=14; remu 100/7 -> 2; divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5.
- Back-to-back mulhu 0xFFFFFFFF×2 then mul 6×7 -> results 1 then 42 on consecutive cycles.
- bne 1,2, pc=0x100, imm=0x20, pre_dir=1, pre_addr=0x120 -> real_dir=1, addr=0x120, pre_right=1; same op with pre_addr=0x124 -> pre_right=0. jalr a=0x203, imm=0 -> addr=0x202, b_type=0.
- Flush 10 cycles into a divide -> no sfu_valid_o, ready=1 next cycle, and a following divu 9/3 returns 3.
- Reset asserted during a divide and while alu_valid_i is high -> all valids 0 immediately, ready=1.
